bp_me_nonsynth_tr_done_monitor: RTL

Non-synthesizable completion monitor for multi-LCE coherence testbenches. It generalises single-LCE trace-done detection to `num_lce_p` trace-replay channels. It counts completed trace operations per channel, tracks elapsed clocks and detects forward-progress stalls with a watchdog. It sits beside the trace nodes and mock LCEs in the CCE testbench and issues a single pass/fail verdict and a bandwidth summary.

---
 rtl/bp_me_nonsynth_tr_done_monitor_pkg.sv | 18 +
 rtl/bp_me_nonsynth_tr_done_monitor_if.sv | 12 +
 rtl/bp_me_nonsynth_tr_chan_mon.sv | 36 +++
 rtl/bp_me_nonsynth_tr_done_monitor.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/bp_me_nonsynth_tr_done_monitor_pkg.sv
// Shared types for the multi-LCE trace completion monitor: FSM states and
// verdict codes reported on fail_code_o.
package bp_me_nonsynth_pkg;

  typedef enum logic [1:0] {
    e_tr_mon_idle = 2'd0,
    e_tr_mon_run  = 2'd1,
    e_tr_mon_pass = 2'd2,
    e_tr_mon_fail = 2'd3
  } bp_me_nonsynth_tr_mon_state_e;

  typedef enum logic [1:0] {
    e_tr_mon_fail_none     = 2'd0,
    e_tr_mon_fail_timeout  = 2'd1,
    e_tr_mon_fail_overflow = 2'd2
  } bp_me_nonsynth_tr_mon_fail_e;

endpackage

// File: rtl/bp_me_nonsynth_tr_done_monitor_if.sv
// Per-channel trace-replay handshake bundle observed by the completion monitor.
// master drives (trace nodes / mock LCEs), slave observes (the monitor).
interface bp_me_nonsynth_tr_done_monitor_if #(
  parameter int num_lce_p = 2
);
  logic [num_lce_p-1:0] tr_done;
  logic [num_lce_p-1:0] op_v;
  logic [num_lce_p-1:0] op_ready;

  modport master (output tr_done, output op_v, output op_ready);
  modport slave  (input  tr_done, input  op_v, input  op_ready);
endinterface

// File: rtl/bp_me_nonsynth_tr_chan_mon.sv
// One trace channel: saturating completed-op counter, sticky done bit and a
// completion strobe consumed by the top-level idle watchdog.
module bp_me_nonsynth_tr_chan_mon #(
  parameter int op_cnt_width_p = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      run,
  input  logic                      tr_done,
  input  logic                      op_v,
  input  logic                      op_ready,
  output logic                      fire,
  output logic                      done,
  output logic                      done_next,
  output logic [op_cnt_width_p-1:0] op_cnt
);

  // Completions and done only matter while the monitor is running, so the
  // counters freeze naturally in IDLE, PASS and FAIL.
  assign fire      = run & op_v & op_ready;
  assign done_next = done | (run & tr_done);

  // Sticky done plus op counter that stops at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done   <= 1'b0;
      op_cnt <= '0;
    end else begin
      done <= done_next;
      if (fire && (op_cnt != '1)) begin
        op_cnt <= op_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_me_nonsynth_tr_done_monitor.sv
// Multi-LCE trace completion monitor: collects per-channel done/op counts,
// counts RUN clocks, runs an idle watchdog and issues a single verdict.
module bp_me_nonsynth_tr_done_monitor
  import bp_me_nonsynth_pkg::*;
#(
  parameter int num_lce_p        = 2,
  parameter int max_clock_cnt_p  = 2**30-1,
  parameter int op_cnt_width_p   = 32,
  parameter int timeout_p        = 100000,
  parameter int bytes_per_op_p   = 64,
  parameter bit finish_on_done_p = 1'b1,
  parameter bit verbose_p        = 1'b1,
  localparam int clock_cnt_width_lp = $clog2(max_clock_cnt_p+1),
  localparam int idle_cnt_width_lp  = (timeout_p > 1) ? $clog2(timeout_p+1) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                en_i,
  bp_me_nonsynth_tr_done_monitor_if.slave     bus,
  output logic [num_lce_p-1:0]                done_mask_o,
  output logic [num_lce_p*op_cnt_width_p-1:0] op_cnt_o,
  output logic [clock_cnt_width_lp-1:0]       clock_cnt_o,
  output logic                                finish_o,
  output logic                                pass_o,
  output logic                                fail_o,
  output logic [1:0]                          fail_code_o
);

  localparam logic [clock_cnt_width_lp-1:0] clock_max_lp =
    clock_cnt_width_lp'(max_clock_cnt_p);
  localparam logic [idle_cnt_width_lp-1:0] idle_limit_lp =
    (timeout_p > 0) ? idle_cnt_width_lp'(timeout_p-1) : '0;

  bp_me_nonsynth_tr_mon_state_e state_r;
  logic [idle_cnt_width_lp-1:0] idle_cnt_r;
  logic [num_lce_p-1:0]         fire;
  logic [num_lce_p-1:0]         done_next;
  logic                         run;
  logic                         any_fire;
  logic                         all_done_next;
  logic                         timeout_hit;
  logic                         overflow_hit;

  assign run = (state_r == e_tr_mon_run);

  for (genvar gi = 0; gi < num_lce_p; gi++) begin : chan
    bp_me_nonsynth_tr_chan_mon #(
      .op_cnt_width_p(op_cnt_width_p)
    ) chan_mon (
      .clk      (clk_i),
      .reset_n  (reset_n_i),
      .run      (run),
      .tr_done  (bus.tr_done[gi]),
      .op_v     (bus.op_v[gi]),
      .op_ready (bus.op_ready[gi]),
      .fire     (fire[gi]),
      .done     (done_mask_o[gi]),
      .done_next(done_next[gi]),
      .op_cnt   (op_cnt_o[gi*op_cnt_width_p +: op_cnt_width_p])
    );
  end

  // Verdict conditions, evaluated only in RUN; the FSM applies the priority
  // PASS > timeout > overflow.
  assign any_fire      = |fire;
  assign all_done_next = &done_next;
  assign timeout_hit   = (timeout_p != 0) && !any_fire && (idle_cnt_r == idle_limit_lp);
  assign overflow_hit  = (clock_cnt_o == clock_max_lp);

  // Monitor FSM with registered verdict outputs and RUN-only counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_tr_mon_idle;
      idle_cnt_r  <= '0;
      clock_cnt_o <= '0;
      finish_o    <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_code_o <= e_tr_mon_fail_none;
    end else begin
      finish_o <= 1'b0;
      case (state_r)
        e_tr_mon_idle: begin
          if (en_i) state_r <= e_tr_mon_run;
        end
        e_tr_mon_run: begin
          if (clock_cnt_o != clock_max_lp) clock_cnt_o <= clock_cnt_o + 1'b1;
          idle_cnt_r <= any_fire ? '0 : idle_cnt_r + 1'b1;
          if (all_done_next) begin
            state_r  <= e_tr_mon_pass;
            pass_o   <= 1'b1;
            finish_o <= 1'b1;
          end else if (timeout_hit) begin
            state_r     <= e_tr_mon_fail;
            fail_o      <= 1'b1;
            fail_code_o <= e_tr_mon_fail_timeout;
            finish_o    <= 1'b1;
          end else if (overflow_hit) begin
            state_r     <= e_tr_mon_fail;
            fail_o      <= 1'b1;
            fail_code_o <= e_tr_mon_fail_overflow;
            finish_o    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  function automatic longint unsigned total_ops();
    longint unsigned sum;
    sum = 0;
    for (int i = 0; i < num_lce_p; i++) begin
      sum += 64'(op_cnt_o[i*op_cnt_width_p +: op_cnt_width_p]);
    end
    return sum;
  endfunction

  // Bandwidth summary and verdict, once, during the first terminal cycle
  always @(posedge clk_i) begin
    if (finish_o) begin
      if (verbose_p) begin
        longint unsigned bytes;
        longint unsigned mbpc;
        bytes = total_ops() * longint'(bytes_per_op_p);
        mbpc  = (clock_cnt_o == '0) ? 0 : (bytes * 1000) / 64'(clock_cnt_o);
        if (pass_o)
          $display("[tr_done_monitor] bytes=%0d clocks=%0d mBPC=%0d Test PASSed",
                   bytes, clock_cnt_o, mbpc);
        else
          $display("[tr_done_monitor] bytes=%0d clocks=%0d mBPC=%0d Test FAILed code %0d",
                   bytes, clock_cnt_o, mbpc, fail_code_o);
      end
      if (finish_on_done_p) $finish;
    end
  end
`endif

endmodule
